lsu_ctrl: RTL and testbench

Load/store control stage between the execute stage and the data-memory read register. It accepts one memory request at a time from the pipeline, drives a word-addressed external data bus with byte strobes and lane-replicated store data, waits for the bus acknowledge with a timeout, and returns aligned, sign- or zero-extended load data. The pipeline is stalled until the response cycle.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 40 ++++
 rtl/lsu_ctrl.sv | 155 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store control stage: access sizes, response
// error codes, FSM states and the latched-request record.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Only the fields still needed once the bus outputs are registered.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sign;
    logic [1:0] off;
  } lsu_lat_t;

  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes and replicated store data, plus
// lane extraction and sign/zero extension of load data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  we_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b  = rdata_i[{off_i, 3'b000} +: 8];
    lane_h  = rdata_i[{off_i[1], 4'b0000} +: 16];
    we_o    = 4'b1111;
    wdata_o = wdata_i;
    ldata_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        we_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        ldata_o = {{24{sign_i & lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        we_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        ldata_o = {{16{sign_i & lane_h[15]}}, lane_h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: single outstanding request, word-addressed bus with
// strobes, ack timeout, and extended load data returned in a one-cycle pulse.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_err,
  output logic        stall
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  lsu_state_e  state_q, state_d;
  lsu_lat_t    lat_q, lat_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic        en_q, en_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic        rv_q, rv_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  logic        idle;
  logic [1:0]  al_size, al_off;
  logic        al_sign;
  logic [3:0]  al_we;
  logic [31:0] al_wdata, al_ldata;

  assign idle = (state_q == ST_IDLE);

  // Steer the incoming request in IDLE, the latched one while accessing.
  assign al_size = idle ? req_size     : lat_q.size;
  assign al_sign = idle ? req_sign     : lat_q.sign;
  assign al_off  = idle ? req_addr[1:0] : lat_q.off;

  lsu_align u_align (
    .size_i  (al_size),
    .sign_i  (al_sign),
    .off_i   (al_off),
    .wdata_i (req_wdata),
    .rdata_i (mem_rdata),
    .we_o    (al_we),
    .wdata_o (al_wdata),
    .ldata_o (al_ldata)
  );

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rv_d    = 1'b0;
    rdata_d = '0;
    err_d   = ERR_NONE;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          lat_d = '{we: req_we, size: req_size, sign: req_sign, off: req_addr[1:0]};
          if (req_illegal(req_size, req_addr[1:0])) begin
            state_d = ST_RESP;
            rv_d    = 1'b1;
            err_d   = ERR_ALIGN;
          end else begin
            state_d = ST_ACCESS;
            en_d    = 1'b1;
            we_d    = req_we ? al_we : 4'b0000;
            addr_d  = {req_addr[31:2], 2'b00};
            wd_d    = al_wdata;
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_inc;
        // Ack is checked first so it wins over a simultaneous timeout.
        if (mem_ack) begin
          state_d = ST_RESP;
          en_d    = 1'b0;
          we_d    = 4'b0000;
          rv_d    = 1'b1;
          rdata_d = lat_q.we ? 32'h0 : al_ldata;
        end else if (TIMEOUT != 0 && cnt_inc == CW'(TIMEOUT)) begin
          state_d = ST_RESP;
          en_d    = 1'b0;
          we_d    = 4'b0000;
          rv_d    = 1'b1;
          err_d   = ERR_TIMEOUT;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      we_q    <= 4'b0000;
      addr_q  <= '0;
      wd_q    <= '0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = idle;
  assign stall      = (state_q == ST_ACCESS) | (idle & req_valid);
  assign mem_en     = en_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wd_q;
  assign resp_valid = rv_q;
  assign resp_data  = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: default-timeout instance (a) and a
// TIMEOUT=4 instance (b) sharing request/data inputs.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic        mem_ack_a = 1'b0, mem_ack_b = 1'b0;
  logic        req_we = 1'b0, req_sign = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;

  logic        rdy_a, en_a, rv_a, st_a, rdy_b, en_b, rv_b, st_b;
  logic [3:0]  we_a, we_b;
  logic [31:0] addr_a, wd_a, rd_a, addr_b, wd_b, rd_b;
  logic [1:0]  err_a, err_b;

  lsu_ctrl dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(rdy_a),
    .req_we(req_we), .req_size(req_size), .req_sign(req_sign),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_en(en_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack_a),
    .resp_valid(rv_a), .resp_data(rd_a), .resp_err(err_a), .stall(st_a)
  );

  lsu_ctrl #(.TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(rdy_b),
    .req_we(req_we), .req_size(req_size), .req_sign(req_sign),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_en(en_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack_b),
    .resp_valid(rv_b), .resp_data(rd_b), .resp_err(err_b), .stall(st_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request on instance a (inst=0) or b (inst=1); ack_dly<0 means never ack.
  task automatic xact(input string tag, input bit inst, input logic we,
                      input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rd, input int ack_dly,
                      input int x_en, input int x_rc, input logic [31:0] x_addr,
                      input logic [3:0] x_we, input logic [31:0] x_wd,
                      input logic [31:0] x_data, input logic [1:0] x_err);
    int en_n = 0, rc = 0, pulses = 0;
    logic [31:0] c_addr = '0, c_wd = '0, c_data = '0;
    logic [3:0]  c_we = '0;
    logic [1:0]  c_err = '0;
    bit ok = 1'b1;
    logic l_en, l_rv, l_st;
    logic [3:0] l_we;
    logic [31:0] l_addr, l_wd, l_rd;
    logic [1:0] l_err;
    @(negedge clk);
    req_we = we; req_size = sz; req_sign = sg; req_addr = addr; req_wdata = wd;
    if (inst) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    #1;
    chk({tag, ":ready"}, inst ? rdy_b : rdy_a, 1);
    chk({tag, ":stall_req"}, inst ? st_b : st_a, 1);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      l_en = inst ? en_b : en_a;     l_rv = inst ? rv_b : rv_a;
      l_st = inst ? st_b : st_a;     l_we = inst ? we_b : we_a;
      l_addr = inst ? addr_b : addr_a; l_wd = inst ? wd_b : wd_a;
      l_rd = inst ? rd_b : rd_a;     l_err = inst ? err_b : err_a;
      req_valid_a = 1'b0; req_valid_b = 1'b0;
      mem_ack_a = 1'b0;   mem_ack_b = 1'b0;
      mem_rdata = ~rd;
      if (l_en) begin
        en_n++;
        if (en_n == 1) begin
          c_addr = l_addr; c_we = l_we; c_wd = l_wd;
        end else if (l_addr !== c_addr || l_we !== c_we || l_wd !== c_wd) ok = 1'b0;
        if (l_st !== 1'b1) ok = 1'b0;
        if (ack_dly >= 0 && en_n == ack_dly + 1) begin
          mem_rdata = rd;
          if (inst) mem_ack_b = 1'b1; else mem_ack_a = 1'b1;
        end
      end
      if (l_rv) begin
        pulses++;
        if (rc == 0) begin rc = k; c_data = l_rd; c_err = l_err; end
        if (l_st !== 1'b0) ok = 1'b0;
      end
      if (rc != 0 && k > rc) break;
    end
    chk({tag, ":en_cycles"}, en_n, x_en);
    chk({tag, ":resp_cycle"}, rc, x_rc);
    chk({tag, ":resp_pulses"}, pulses, 1);
    chk({tag, ":mem_addr"}, c_addr, x_addr);
    chk({tag, ":mem_we"}, c_we, x_we);
    chk({tag, ":mem_wdata"}, c_wd, x_wd);
    chk({tag, ":resp_data"}, c_data, x_data);
    chk({tag, ":resp_err"}, c_err, x_err);
    chk({tag, ":stall_bus_stable"}, ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst:ready_a", rdy_a, 1);
    chk("rst:en_a", en_a, 0);
    chk("rst:we_a", we_a, 0);
    chk("rst:addr_a", addr_a, 0);
    chk("rst:wdata_a", wd_a, 0);
    chk("rst:rv_a", rv_a, 0);
    chk("rst:rdata_a", rd_a, 0);
    chk("rst:err_a", err_a, 0);
    chk("rst:stall_a", st_a, 0);
    chk("rst:ready_b", rdy_b, 1);

    //    tag    inst we  size   sg   addr          wdata          rdata          dly en rc x_addr        x_we     x_wdata        x_data         x_err
    xact("sb",   0, 1, 2'b00, 0, 32'h0000_1003, 32'h0000_00A5, 32'h0,         0,  1, 2, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0,         2'b00);
    xact("lb",   0, 0, 2'b00, 1, 32'h0000_2002, 32'h0,         32'h0080_0000, 0,  1, 2, 32'h0000_2000, 4'b0000, 32'h0,         32'hFFFF_FF80, 2'b00);
    xact("lbu",  0, 0, 2'b00, 0, 32'h0000_2002, 32'h0,         32'h0080_0000, 0,  1, 2, 32'h0000_2000, 4'b0000, 32'h0,         32'h0000_0080, 2'b00);
    xact("lh",   0, 0, 2'b01, 1, 32'h0000_2002, 32'h0,         32'h8001_1234, 0,  1, 2, 32'h0000_2000, 4'b0000, 32'h0,         32'hFFFF_8001, 2'b00);
    xact("lw_mis",0,0, 2'b10, 0, 32'h0000_2001, 32'h0,         32'h0,         0,  0, 1, 32'h0,         4'b0000, 32'h0,         32'h0,         2'b01);
    xact("lw_dly",0,0, 2'b10, 0, 32'h0000_3000, 32'h0,         32'hDEAD_BEEF, 5,  6, 7, 32'h0000_3000, 4'b0000, 32'h0,         32'hDEAD_BEEF, 2'b00);
    xact("sh",   0, 1, 2'b01, 0, 32'h0000_0002, 32'h1234_BEEF, 32'h0,         1,  2, 3, 32'h0000_0000, 4'b1100, 32'hBEEF_BEEF, 32'h0,         2'b00);
    xact("sz11", 0, 1, 2'b11, 0, 32'h0000_0010, 32'h5555_5555, 32'h0,         0,  0, 1, 32'h0,         4'b0000, 32'h0,         32'h0,         2'b01);
    xact("sh_mis",0,1, 2'b01, 0, 32'h0000_0011, 32'h5555_5555, 32'h0,         0,  0, 1, 32'h0,         4'b0000, 32'h0,         32'h0,         2'b01);
    xact("lhu",  0, 0, 2'b01, 0, 32'h0000_0040, 32'h0,         32'h7777_F00D, 0,  1, 2, 32'h0000_0040, 4'b0000, 32'h0,         32'h0000_F00D, 2'b00);
    xact("sb1",  0, 1, 2'b00, 0, 32'h0000_0021, 32'hFFFF_FF3C, 32'h0,         0,  1, 2, 32'h0000_0020, 4'b0010, 32'h3C3C_3C3C, 32'h0,         2'b00);
    xact("to",   1, 0, 2'b10, 0, 32'h0000_4000, 32'h0,         32'h1111_2222, -1, 4, 5, 32'h0000_4000, 4'b0000, 32'h0,         32'h0,         2'b10);
    xact("to_ack",1,0, 2'b10, 0, 32'h0000_4004, 32'h0,         32'h1234_5678, 3,  4, 5, 32'h0000_4004, 4'b0000, 32'h0,         32'h1234_5678, 2'b00);

    // Reset while waiting for ack: request discarded, no response.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_sign = 1'b0;
    req_addr = 32'h0000_5000; req_wdata = 32'hCAFE_F00D; req_valid_a = 1'b1;
    @(negedge clk);
    req_valid_a = 1'b0;
    chk("rstmid:en_before", en_a, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid:en", en_a, 0);
    chk("rstmid:we", we_a, 0);
    chk("rstmid:addr", addr_a, 0);
    chk("rstmid:wdata", wd_a, 0);
    chk("rstmid:rv", rv_a, 0);
    chk("rstmid:ready", rdy_a, 1);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rv_a || en_a) seen++;
    end
    chk("rstmid:quiet", seen, 0);
    xact("post_rst", 0, 1, 2'b10, 0, 32'h0000_6000, 32'h1122_3344, 32'h0, 0,
         1, 2, 32'h0000_6000, 4'b1111, 32'h1122_3344, 32'h0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
